demultiplexer_8bits: RTL
========================

// Module: demultiplexer_8bits
// PURPOSE
//  Inverse of the 8-bit 2:1 select path: steers one 8-bit input stream to one of two
//  output channels chosen by select bit s. Each channel buffers data in a small FIFO
//  with valid/ready handshakes, so the consumers can stall independently.
//  Sits between a single byte producer (switch/keypad/serial sampler) and two consumers
//  (e.g. display digit latch, LED register).
// PARAMETERS
//  WIDTH  8  data width of input and both outputs
//  DEPTH  2  entries per channel FIFO; power of two, >= 2
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  i          in   WIDTH  input data byte
//  s          in   1      channel select: 0 -> out0, 1 -> out1
//  in_valid   in   1      producer presents i/s this cycle
//  in_ready   out  1      selected channel can accept; transfer when in_valid & in_ready
//  out0       out  WIDTH  channel-0 head data (0 when out0_valid=0)
//  out0_valid out  1      channel-0 FIFO non-empty
//  out0_ready in   1      consumer 0 takes head when out0_valid & out0_ready
//  out1       out  WIDTH  channel-1 head data (0 when out1_valid=0)
//  out1_valid out  1      channel-1 FIFO non-empty
//  out1_ready in   1      consumer 1 takes head
//  count0     out  $clog2(DEPTH+1)  channel-0 occupancy
//  count1     out  $clog2(DEPTH+1)  channel-1 occupancy
// BEHAVIOUR
//  - Reset (rst_n=0, async assert, sync-to-clk deassert use): both FIFOs empty, pointers 0,
//    count0=count1=0, out0_valid=out1_valid=0, out0=out1=0; in_ready follows combinational rule.
//  - in_ready = ~full[s]; combinational from s and registered full flags only (no dependence
//    on out*_ready). A full channel refuses a push even if it pops the same cycle.
//  - Push: on edge with in_valid & in_ready, i written into FIFO[s]; the other channel untouched.
//  - Latency: byte pushed at edge N appears at outS with outS_valid=1 after edge N (1 cycle)
//    if FIFO was empty; otherwise behind earlier entries, strict FIFO order per channel.
//  - Pop: on edge with outX_valid & outX_ready, head advances; outX shows next entry or 0.
//  - Simultaneous push and pop on same non-full channel: count unchanged, both take effect.
//    Push+pop on empty channel: pop ignored (valid=0), push lands; count 0->1.
//  - Pointers wrap modulo DEPTH; count saturates nowhere (guarded by full/empty).
//  - in_valid=1 with in_ready=0: no state change; producer must hold i and s stable until accepted.
//  - outX_ready while outX_valid=0: no effect.
//  - Reset mid-operation: all queued data discarded immediately; first push after release OK.
//  - Channel FSM per FIFO: EMPTY -(push)-> PARTIAL -(count=DEPTH)-> FULL; FULL -(pop)-> PARTIAL;
//    PARTIAL -(pop, count 1->0)-> EMPTY. For DEPTH=2 PARTIAL is count=1.
// STRUCTURE
//  - Shared include (demux_defs.vh): default WIDTH, DEPTH, CH0/CH1 select encodings.
//  - One sub-module: demux_channel_fifo (WIDTH, DEPTH; push, data_in, full, pop, head,
//    valid, count), instantiated twice; top holds only select steering and in_ready mux.
// TESTING
//  1 Reset: rst_n=0 with in_valid=1 -> out0_valid=out1_valid=0, count0=count1=0, out0=out1=0.
//  2 Routing: push i=8'hA5 s=0, then i=8'h3C s=1 -> next cycle out0=A5, out1=3C, both valid.
//  3 Full/backpressure: out0_ready=0, push 8'h01,8'h02 s=0 -> count0=2, in_ready=0 for s=0
//    but 1 for s=1; third push 8'h03 s=0 held, not lost; drain gives 01,02,03 in order.
//  4 Simultaneous: channel 1 count=1 (8'h10), push 8'h11 s=1 with out1_ready=1 -> count1 stays 1,
//    out1=11 next cycle; full channel with pop+push -> push refused.
//  5 Wrap: 6 push/pop pairs on channel 0 (8'h20..8'h25) -> exact order, pointers wrap, count<=2.
//  6 Mid-op reset: both FIFOs full, pulse rst_n low between edges -> outputs 0 immediately
//    (async); after release push 8'hFF s=1 -> out1=FF one cycle later.

Source files
------------

// File: rtl/demultiplexer_8bits_pkg.sv
// Shared defaults for the byte demultiplexer: data width, FIFO depth,
// channel select encodings and the per-channel occupancy state type.
package demultiplexer_8bits_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DEPTH = 2;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  typedef enum logic [1:0] {
    CH_EMPTY   = 2'd0,
    CH_PARTIAL = 2'd1,
    CH_FULL    = 2'd2
  } ch_state_t;

endpackage

// File: rtl/demultiplexer_8bits_channel_fifo.sv
// One output channel of the demultiplexer: a DEPTH-entry FIFO with
// registered full/valid flags derived from an EMPTY/PARTIAL/FULL state machine.
module demux_channel_fifo
  import demultiplexer_8bits_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic [WIDTH-1:0]               data_in,
  output logic                           full,
  input  logic                           pop,
  output logic [WIDTH-1:0]               head,
  output logic                           valid,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [PW-1:0]    wr_ptr_next, rd_ptr_next;
  logic [CW-1:0]    count_next;
  ch_state_t        state, state_next;
  logic             push_ok, pop_ok;

  assign full  = (state == CH_FULL);
  assign valid = (state != CH_EMPTY);
  assign head  = valid ? mem[rd_ptr] : '0;

  // Push is refused on a full channel even if it pops in the same cycle.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & valid;

  always_comb begin
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    count_next  = count + CW'(push_ok) - CW'(pop_ok);
    state_next  = state;
    if (push_ok) wr_ptr_next = wr_ptr + PW'(1);
    if (pop_ok)  rd_ptr_next = rd_ptr + PW'(1);
    if (count_next == '0)
      state_next = CH_EMPTY;
    else if (count_next == CW'(DEPTH))
      state_next = CH_FULL;
    else
      state_next = CH_PARTIAL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= CH_EMPTY;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      state  <= state_next;
      count  <= count_next;
      wr_ptr <= wr_ptr_next;
      rd_ptr <= rd_ptr_next;
    end
  end

  // Storage needs no reset: head is masked to zero whenever the channel is empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= data_in;
  end

endmodule

// File: rtl/demultiplexer_8bits.sv
// Steers one byte stream to one of two buffered output channels chosen by s;
// each channel has its own valid/ready FIFO so consumers stall independently.
module demultiplexer_8bits
  import demultiplexer_8bits_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           i,
  input  logic                       s,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out0,
  output logic                       out0_valid,
  input  logic                       out0_ready,
  output logic [WIDTH-1:0]           out1,
  output logic                       out1_valid,
  input  logic                       out1_ready,
  output logic [$clog2(DEPTH+1)-1:0] count0,
  output logic [$clog2(DEPTH+1)-1:0] count1
);

  logic full0, full1;
  logic push0, push1;

  assign in_ready = (s == CH1) ? ~full1 : ~full0;
  assign push0    = in_valid & in_ready & (s == CH0);
  assign push1    = in_valid & in_ready & (s == CH1);

  demux_channel_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ch0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push0),
    .data_in (i),
    .full    (full0),
    .pop     (out0_ready),
    .head    (out0),
    .valid   (out0_valid),
    .count   (count0)
  );

  demux_channel_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ch1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push1),
    .data_in (i),
    .full    (full1),
    .pop     (out1_ready),
    .head    (out1),
    .valid   (out1_valid),
    .count   (count1)
  );

endmodule
